// File: rtl/ps2_line_assembler_if.sv
// ps2_line_if: committed-line hand-off from the PS/2 line assembler to the
// display controller.
//   ps2_line_content  last committed line, character 0 in the MSB byte
//   ps2_line_ready    one-cycle pulse, content is valid in the same cycle
// master = producer (line assembler), slave = consumer (display controller).
interface ps2_line_if #(parameter int CHARS = 32);
  logic [8*CHARS-1:0] ps2_line_content;
  logic               ps2_line_ready;

  modport master (output ps2_line_content, output ps2_line_ready);
  modport slave  (input  ps2_line_content, input  ps2_line_ready);
endinterface

// File: rtl/ps2_line_assembler.sv
// ps2_line_assembler: builds a CHARS-character ASCII line from decoded PS/2
// keystrokes and commits it on Enter.
//   clock       system clock, rising edge
//   reset       asynchronous, active-high
//   key_strobe  one-cycle pulse marking a decoded key
//   key_ascii   ASCII code, valid with key_strobe
//   line_bus    ps2_line_if master: committed line + ready pulse
//   edit_line   live edit buffer (unused positions are spaces)
//   cursor      next write position, 0..CHARS
//   overflow    sticky: a printable key was dropped on a full line
//
// state  | meaning
// EDIT   | process one key per cycle (pending entry first, else the strobe)
// COMMIT | one cycle: clear edit buffer, cursor, overflow; end ready pulse
module ps2_line_assembler #(
  parameter  int CHARS = 32,
  localparam int CW    = $clog2(CHARS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_strobe,
  input  logic [7:0]         key_ascii,
  ps2_line_if.master         line_bus,
  output logic [8*CHARS-1:0] edit_line,
  output logic [CW-1:0]      cursor,
  output logic               overflow
);

  typedef enum logic {EDIT, COMMIT} state_t;

  localparam logic [8*CHARS-1:0] SPACES = {CHARS{8'h20}};
  localparam logic [CW-1:0]      FULL   = CW'(CHARS);
  localparam logic [CW-1:0]      ONE    = CW'(1);
  localparam logic [7:0]         KEY_BS = 8'h08;
  localparam logic [7:0]         KEY_CR = 8'h0D;

  state_t             state;
  logic               pend_valid;
  logic [7:0]         pend_data;
  logic [8*CHARS-1:0] content_q;
  logic               ready_q;

  logic               proc_valid;
  logic [7:0]         proc_code;
  logic               is_print;
  logic               wr_en;
  logic [CW-1:0]      wr_pos;
  logic [7:0]         wr_byte;
  logic [8*CHARS-1:0] edit_nxt;

  assign line_bus.ps2_line_content = content_q;
  assign line_bus.ps2_line_ready   = ready_q;

  // A pending key always goes ahead of a same-cycle strobe to keep key order.
  always_comb begin
    proc_valid = pend_valid | key_strobe;
    proc_code  = pend_valid ? pend_data : key_ascii;
    is_print   = (proc_code >= 8'h20) && (proc_code <= 8'h7E);
    wr_en      = 1'b0;
    wr_pos     = cursor;
    wr_byte    = proc_code;
    if (proc_valid && is_print && cursor != FULL) begin
      wr_en = 1'b1;
    end else if (proc_valid && proc_code == KEY_BS && cursor != '0) begin
      wr_en   = 1'b1;
      wr_pos  = cursor - ONE;
      wr_byte = 8'h20;
    end
    edit_nxt = edit_line;
    for (int i = 0; i < CHARS; i++) begin
      if (wr_en && int'(wr_pos) == i) edit_nxt[8*(CHARS-1-i) +: 8] = wr_byte;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= EDIT;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      content_q  <= SPACES;
      ready_q    <= 1'b0;
      edit_line  <= SPACES;
      cursor     <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        EDIT: begin
          ready_q <= 1'b0;
          // While the pending entry is consumed, a new strobe takes its place.
          pend_valid <= pend_valid & key_strobe;
          if (pend_valid) pend_data <= key_ascii;
          edit_line <= edit_nxt;
          if (proc_valid) begin
            if (is_print) begin
              if (cursor != FULL) cursor   <= cursor + ONE;
              else                overflow <= 1'b1;
            end else if (proc_code == KEY_BS) begin
              if (cursor != '0) cursor <= cursor - ONE;
            end else if (proc_code == KEY_CR && cursor != '0) begin
              content_q <= edit_line;
              ready_q   <= 1'b1;
              state     <= COMMIT;
            end
          end
        end
        COMMIT: begin
          edit_line <= SPACES;
          cursor    <= '0;
          overflow  <= 1'b0;
          ready_q   <= 1'b0;
          state     <= EDIT;
          if (key_strobe) begin
            pend_valid <= 1'b1;
            pend_data  <= key_ascii;
          end
        end
        default: state <= EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_line_assembler.sv
module tb_ps2_line_assembler;
  localparam int CHARS = 32;
  localparam logic [255:0] SPACES = {32{8'h20}};

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         key_strobe = 1'b0;
  logic [7:0]   key_ascii = 8'h00;
  logic [255:0] edit_line;
  logic [5:0]   cursor;
  logic         overflow;

  ps2_line_if #(.CHARS(CHARS)) line_bus ();

  ps2_line_assembler #(.CHARS(CHARS)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_strobe (key_strobe),
    .key_ascii  (key_ascii),
    .line_bus   (line_bus),
    .edit_line  (edit_line),
    .cursor     (cursor),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: a key queue plus a byte array for the line.
  logic [7:0] m_line[CHARS];
  logic [7:0] m_content[CHARS];
  int         m_cur;
  bit         m_ovf;
  bit         m_ready;
  bit         m_commit;
  logic [7:0] m_keys[$];

  function automatic logic [255:0] pack(input logic [7:0] b[CHARS]);
    logic [255:0] v;
    for (int i = 0; i < CHARS; i++) v[255-8*i -: 8] = b[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CHARS; i++) begin
      m_line[i]    = 8'h20;
      m_content[i] = 8'h20;
    end
    m_cur = 0; m_ovf = 0; m_ready = 0; m_commit = 0;
    m_keys.delete();
  endtask

  task automatic model_step(input bit stb, input logic [7:0] code);
    logic [7:0] k;
    if (stb) m_keys.push_back(code);
    if (m_commit) begin
      for (int i = 0; i < CHARS; i++) m_line[i] = 8'h20;
      m_cur = 0; m_ovf = 0; m_ready = 0; m_commit = 0;
    end else begin
      m_ready = 0;
      if (m_keys.size() > 0) begin
        k = m_keys.pop_front();
        if (k >= 8'h20 && k <= 8'h7E) begin
          if (m_cur < CHARS) begin m_line[m_cur] = k; m_cur++; end
          else m_ovf = 1;
        end else if (k == 8'h08) begin
          if (m_cur > 0) begin m_cur--; m_line[m_cur] = 8'h20; end
        end else if (k == 8'h0D) begin
          if (m_cur > 0) begin
            m_content = m_line;
            m_ready = 1; m_commit = 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":edit"},    edit_line,                 pack(m_line));
    chk({tag, ":cursor"},  256'(cursor),              256'(m_cur));
    chk({tag, ":ovf"},     256'(overflow),            256'(m_ovf));
    chk({tag, ":ready"},   256'(line_bus.ps2_line_ready), 256'(m_ready));
    chk({tag, ":content"}, line_bus.ps2_line_content, pack(m_content));
  endtask

  task automatic cycle(input bit stb, input logic [7:0] code, input string tag);
    key_strobe = stb;
    key_ascii  = code;
    @(posedge clock);
    model_step(stb, code);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    key_strobe = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check_model("rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        stb;
    logic [7:0]  code;
    logic [5:0]  cur;
    logic        rdy;
    logic [23:0] head;
  } vec_t;

  vec_t tv[15];

  initial begin
    int run;
    bit s;
    logic [7:0] c;
    int r;

    tv[0]  = '{1'b1, 8'h48, 6'd1, 1'b0, 24'h482020};
    tv[1]  = '{1'b1, 8'h49, 6'd2, 1'b0, 24'h484920};
    tv[2]  = '{1'b1, 8'h0D, 6'd2, 1'b1, 24'h484920};
    tv[3]  = '{1'b0, 8'h00, 6'd0, 1'b0, 24'h202020};
    tv[4]  = '{1'b1, 8'h41, 6'd1, 1'b0, 24'h412020};
    tv[5]  = '{1'b1, 8'h42, 6'd2, 1'b0, 24'h414220};
    tv[6]  = '{1'b1, 8'h08, 6'd1, 1'b0, 24'h412020};
    tv[7]  = '{1'b1, 8'h43, 6'd2, 1'b0, 24'h414320};
    tv[8]  = '{1'b0, 8'h00, 6'd2, 1'b0, 24'h414320};
    tv[9]  = '{1'b1, 8'h0D, 6'd2, 1'b1, 24'h414320};
    tv[10] = '{1'b0, 8'h00, 6'd0, 1'b0, 24'h202020};
    tv[11] = '{1'b1, 8'h08, 6'd0, 1'b0, 24'h202020};
    tv[12] = '{1'b1, 8'h0D, 6'd0, 1'b0, 24'h202020};
    tv[13] = '{1'b0, 8'h00, 6'd0, 1'b0, 24'h202020};
    tv[14] = '{1'b1, 8'h01, 6'd0, 1'b0, 24'h202020};

    do_reset();
    chk("reset_content", line_bus.ps2_line_content, SPACES);

    for (int i = 0; i < 15; i++) begin
      cycle(tv[i].stb, tv[i].code, "tbl");
      chk($sformatf("tv%0d_cursor", i), 256'(cursor), 256'(tv[i].cur));
      chk($sformatf("tv%0d_ready", i), 256'(line_bus.ps2_line_ready), 256'(tv[i].rdy));
      chk($sformatf("tv%0d_head", i), 256'(edit_line[255:232]), 256'(tv[i].head));
      if (i == 2)
        chk("hi_content", line_bus.ps2_line_content, {16'h4849, {30{8'h20}}});
      if (i == 9)
        chk("ac_content", line_bus.ps2_line_content, {16'h4143, {30{8'h20}}});
    end
    chk("empty_enter_content", line_bus.ps2_line_content, {16'h4143, {30{8'h20}}});

    // 33 x: line fills, last key dropped
    for (int i = 0; i < 33; i++) begin
      cycle(1'b1, 8'h78, "ovf_type");
      cycle(1'b0, 8'h00, "ovf_gap");
    end
    chk("full_cursor", 256'(cursor), 256'(32));
    chk("full_line", edit_line, {32{8'h78}});
    chk("full_ovf", 256'(overflow), 256'(1));
    cycle(1'b1, 8'h0D, "ovf_enter");
    chk("full_ready", 256'(line_bus.ps2_line_ready), 256'(1));
    chk("full_content", line_bus.ps2_line_content, {32{8'h78}});
    cycle(1'b0, 8'h00, "ovf_commit");
    chk("ovf_cleared", 256'(overflow), 256'(0));

    // Enter then Z in the COMMIT cycle
    cycle(1'b1, 8'h4B, "ez_k");
    cycle(1'b0, 8'h00, "ez_gap");
    cycle(1'b1, 8'h0D, "ez_enter");
    chk("ez_ready", 256'(line_bus.ps2_line_ready), 256'(1));
    cycle(1'b1, 8'h5A, "ez_z");
    chk("ez_commit_cursor", 256'(cursor), 256'(0));
    cycle(1'b0, 8'h00, "ez_after");
    chk("ez_z_byte", 256'(edit_line[255:248]), 256'(8'h5A));
    chk("ez_z_cursor", 256'(cursor), 256'(1));
    chk("ez_content", line_bus.ps2_line_content, {8'h4B, {31{8'h20}}});
    cycle(1'b1, 8'h08, "ez_bs");
    cycle(1'b0, 8'h00, "ez_idle");

    // Reset during the ready pulse
    cycle(1'b1, 8'h50, "rr_p");
    cycle(1'b1, 8'h0D, "rr_enter");
    chk("rr_ready_before", 256'(line_bus.ps2_line_ready), 256'(1));
    key_strobe = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rr_ready_cut", 256'(line_bus.ps2_line_ready), 256'(0));
    chk("rr_content", line_bus.ps2_line_content, SPACES);
    chk("rr_cursor", 256'(cursor), 256'(0));
    check_model("rr");
    @(posedge clock);
    #1;
    reset = 1'b0;
    cycle(1'b1, 8'h51, "rr_q");
    cycle(1'b1, 8'h0D, "rr_enter2");
    chk("rr_q_ready", 256'(line_bus.ps2_line_ready), 256'(1));
    chk("rr_q_content", line_bus.ps2_line_content, {8'h51, {31{8'h20}}});
    cycle(1'b0, 8'h00, "rr_commit");

    // Randomized run, at most two strobes on consecutive cycles
    run = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        run = 0;
      end
      s = (run < 2) && ($urandom_range(0, 99) < 50);
      run = s ? run + 1 : 0;
      r = $urandom_range(0, 99);
      if (r < 65)      c = 8'($urandom_range(32, 126));
      else if (r < 78) c = 8'h08;
      else if (r < 86) c = 8'h0D;
      else if (r < 93) c = 8'($urandom_range(0, 31));
      else             c = 8'($urandom_range(127, 255));
      cycle(s, s ? c : 8'($urandom_range(0, 255)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
